audio_filter_ctrl: RTL

- Host-facing configuration sequencer for the audio filter chain (IIR filter, DC blocker, mixer).
- Accepts 32-bit register writes from the bridge into a shadow bank.
- On commit, ramps attenuation to silence at sample rate, swaps shadow to active config, holds the filter in reset for a settle window, then ramps back to the new attenuation.
- Prevents clicks and transient IIR instability when coefficients change mid-playback.

---
 rtl/audio_pkg.sv | 52 +++++
 rtl/audio_filter_ctrl_att_ramp.sv | 22 ++
 rtl/audio_filter_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types for the audio filter configuration sequencer: config record,
// sequencer states, register map and the shadow-bank write decoder.
package audio_pkg;

    typedef struct packed {
        logic [31:0] rate;
        logic [39:0] cx;
        logic [7:0]  cx0;
        logic [7:0]  cx1;
        logic [7:0]  cx2;
        logic [23:0] cy0;
        logic [23:0] cy1;
        logic [23:0] cy2;
        logic [4:0]  att;
        logic [1:0]  mix;
        logic        is_signed;
    } filt_cfg_t;

    typedef enum logic [2:0] {IDLE, RAMP_DN, SWAP, SETTLE, RAMP_UP} ctrl_state_t;

    localparam logic [3:0] REG_RATE    = 4'd0;
    localparam logic [3:0] REG_CX_LO   = 4'd1;
    localparam logic [3:0] REG_CX_HI   = 4'd2;
    localparam logic [3:0] REG_CX_TAPS = 4'd3;
    localparam logic [3:0] REG_CY0     = 4'd4;
    localparam logic [3:0] REG_CY1     = 4'd5;
    localparam logic [3:0] REG_CY2     = 4'd6;
    localparam logic [3:0] REG_MODE    = 4'd7;
    localparam logic [3:0] REG_COMMIT  = 4'd8;

    localparam logic [4:0] ATT_MAX = 5'd31;

    // Applies one bridge write to a config record; unmapped indices leave it untouched.
    function automatic filt_cfg_t cfg_write(input filt_cfg_t c, input logic [3:0] a,
                                            input logic [31:0] d);
        filt_cfg_t r;
        r = c;
        case (a)
            REG_RATE:    r.rate = d;
            REG_CX_LO:   r.cx[31:0] = d;
            REG_CX_HI:   r.cx[39:32] = d[7:0];
            REG_CX_TAPS: {r.cx2, r.cx1, r.cx0} = d[23:0];
            REG_CY0:     r.cy0 = d[23:0];
            REG_CY1:     r.cy1 = d[23:0];
            REG_CY2:     r.cy2 = d[23:0];
            REG_MODE:    {r.is_signed, r.mix, r.att} = d[7:0];
            default:     ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/audio_filter_ctrl_att_ramp.sv
// Attenuation ramp: steps the current value one unit toward limit on each
// enabled sample strobe; done flags that the limit has been reached.
module att_ramp (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       step,
    input  logic [4:0] limit,
    output logic [4:0] att,
    output logic       done
);

    assign done = (att == limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            att <= 5'd0;
        else if (en && step && !done)
            att <= (att < limit) ? att + 5'd1 : att - 5'd1;
    end

endmodule

// File: rtl/audio_filter_ctrl.sv
// Configuration sequencer: mutes, swaps shadow config into the active bank,
// holds the filter in reset while it settles, then unmutes to the new level.
module audio_filter_ctrl
    import audio_pkg::*;
#(
    parameter int          SETTLE_SAMPLES = 64,
    parameter logic [31:0] DEF_RATE       = 32'd7056000,
    parameter logic [39:0] DEF_CX         = 40'd4258969,
    parameter logic [7:0]  DEF_CX0        = 8'd3,
    parameter logic [7:0]  DEF_CX1        = 8'd3,
    parameter logic [7:0]  DEF_CX2        = 8'd1,
    parameter logic [23:0] DEF_CY0        = 24'hA1_24C9,
    parameter logic [23:0] DEF_CY1        = 24'h5D_BD9A,
    parameter logic [23:0] DEF_CY2        = 24'hE1_1EA9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_ce,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        flt_reset,
    output logic [31:0] flt_rate,
    output logic [39:0] cx,
    output logic [7:0]  cx0,
    output logic [7:0]  cx1,
    output logic [7:0]  cx2,
    output logic [23:0] cy0,
    output logic [23:0] cy1,
    output logic [23:0] cy2,
    output logic [4:0]  att,
    output logic [1:0]  mix,
    output logic        is_signed
);

    localparam int CNT_W = $clog2(SETTLE_SAMPLES + 1);

    localparam filt_cfg_t DEF_CFG = '{
        rate: DEF_RATE, cx: DEF_CX, cx0: DEF_CX0, cx1: DEF_CX1, cx2: DEF_CX2,
        cy0: DEF_CY0, cy1: DEF_CY1, cy2: DEF_CY2, att: 5'd0, mix: 2'd0, is_signed: 1'b0
    };

    ctrl_state_t      state, next_state;
    filt_cfg_t        shadow, active;
    logic             pending;
    logic [CNT_W-1:0] settle_cnt;
    logic             commit;
    logic             ramp_en;
    logic [4:0]       ramp_limit;
    logic             ramp_done;

    assign commit = wr_en && (wr_addr == REG_COMMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            shadow <= DEF_CFG;
        else if (wr_en)
            shadow <= cfg_write(shadow, wr_addr, wr_data);
    end

    // The copy uses the registered shadow, so a write in the SWAP cycle misses it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            active <= DEF_CFG;
        else if (state == SWAP)
            active <= shadow;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= 1'b0;
            settle_cnt <= '0;
            flt_reset  <= 1'b1;
        end else begin
            state     <= next_state;
            flt_reset <= (next_state == SWAP) || (next_state == SETTLE);
            if (state == IDLE)
                pending <= 1'b0;
            else if (commit)
                pending <= 1'b1;
            if (state != SETTLE)
                settle_cnt <= '0;
            else if (sample_ce && settle_cnt != CNT_W'(SETTLE_SAMPLES))
                settle_cnt <= settle_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        ramp_en    = 1'b0;
        ramp_limit = ATT_MAX;
        case (state)
            IDLE:    if (commit || pending) next_state = RAMP_DN;
            RAMP_DN: begin
                ramp_en = 1'b1;
                if (sample_ce && ramp_done) next_state = SWAP;
            end
            SWAP:    next_state = SETTLE;
            SETTLE:  if (settle_cnt == CNT_W'(SETTLE_SAMPLES)) next_state = RAMP_UP;
            RAMP_UP: begin
                ramp_en    = 1'b1;
                ramp_limit = active.att;
                if (sample_ce && ramp_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    att_ramp u_ramp (
        .clk   (clk),
        .reset (reset),
        .en    (ramp_en),
        .step  (sample_ce),
        .limit (ramp_limit),
        .att   (att),
        .done  (ramp_done)
    );

    assign busy      = (state != IDLE);
    assign flt_rate  = active.rate;
    assign cx        = active.cx;
    assign cx0       = active.cx0;
    assign cx1       = active.cx1;
    assign cx2       = active.cx2;
    assign cy0       = active.cy0;
    assign cy1       = active.cy1;
    assign cy2       = active.cy2;
    assign mix       = active.mix;
    assign is_signed = active.is_signed;

endmodule
